// File: rtl/ppu_vram_arbiter.sv
// Shares the PPU VRAM port between the PPUDATA CPU path and render fetches.
// Render has priority; a one-deep CPU pending slot is forced through after STARVE_LIMIT lost slots.
module ppu_vram_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_overrun,
    input  logic        cpu_overrun_clr,
    input  logic        rnd_req,
    input  logic [13:0] rnd_addr,
    output logic        rnd_grant,
    output logic        rnd_valid,
    output logic [7:0]  rnd_rdata,
    output logic [13:0] vram_a,
    output logic        vram_r,
    output logic        vram_w,
    output logic [7:0]  vram_dout,
    input  logic [7:0]  vram_din
);

    localparam logic [1:0] CPU_IDLE   = 2'd0;
    localparam logic [1:0] CPU_PEND   = 2'd1;
    localparam logic [1:0] CPU_RDWAIT = 2'd2;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [1:0]       state_r;
    logic             pend_we_r;
    logic [13:0]      pend_addr_r;
    logic [7:0]       pend_wdata_r;
    logic [CNT_W-1:0] starve_cnt_r;

    logic slot_s;
    logic pend_s;
    logic cpu_win_s;
    logic rnd_win_s;

    // Reset also gates the slot so no strobe escapes while reset is held.
    assign slot_s   = ce & ~reset;
    assign pend_s   = (state_r == CPU_PEND);
    assign cpu_busy = (state_r != CPU_IDLE);

    // Slot winner: starved CPU first, then render, then any pending CPU access.
    always_comb begin
        cpu_win_s = 1'b0;
        rnd_win_s = 1'b0;
        if (!slot_s) begin
            cpu_win_s = 1'b0;
            rnd_win_s = 1'b0;
        end else if (pend_s && (starve_cnt_r >= LIMIT_C)) begin
            cpu_win_s = 1'b1;
        end else if (rnd_req) begin
            rnd_win_s = 1'b1;
        end else if (pend_s) begin
            cpu_win_s = 1'b1;
        end else begin
            cpu_win_s = 1'b0;
        end
    end

    // VRAM port drive for the current slot owner.
    always_comb begin
        rnd_grant = rnd_win_s;
        vram_r    = rnd_win_s | (cpu_win_s & ~pend_we_r);
        vram_w    = cpu_win_s & pend_we_r;
        vram_a    = 14'd0;
        vram_dout = 8'd0;
        if (rnd_win_s) begin
            vram_a = rnd_addr;
        end else if (cpu_win_s) begin
            vram_a = pend_addr_r;
            if (pend_we_r) begin
                vram_dout = pend_wdata_r;
            end else begin
                vram_dout = 8'd0;
            end
        end else begin
            vram_a = 14'd0;
        end
    end

    // CPU pending slot, read-buffer capture and starvation tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= CPU_IDLE;
            pend_we_r    <= 1'b0;
            pend_addr_r  <= 14'd0;
            pend_wdata_r <= 8'd0;
            starve_cnt_r <= '0;
            cpu_rdata    <= 8'd0;
            cpu_overrun  <= 1'b0;
        end else if (ce) begin
            case (state_r)
                CPU_IDLE: begin
                    if (cpu_req) begin
                        pend_we_r    <= cpu_we;
                        pend_addr_r  <= cpu_addr;
                        pend_wdata_r <= cpu_wdata;
                        state_r      <= CPU_PEND;
                    end
                end
                CPU_PEND: begin
                    if (cpu_win_s) begin
                        state_r <= pend_we_r ? CPU_IDLE : CPU_RDWAIT;
                    end
                end
                CPU_RDWAIT: begin
                    cpu_rdata <= vram_din;
                    state_r   <= CPU_IDLE;
                end
                default: begin
                    state_r <= CPU_IDLE;
                end
            endcase

            if (cpu_win_s) begin
                starve_cnt_r <= '0;
            end else if (rnd_win_s && pend_s && (starve_cnt_r < LIMIT_C)) begin
                starve_cnt_r <= starve_cnt_r + ONE_C;
            end

            // A set event outranks a simultaneous clear.
            if (cpu_req && (state_r != CPU_IDLE)) begin
                cpu_overrun <= 1'b1;
            end else if (cpu_overrun_clr) begin
                cpu_overrun <= 1'b0;
            end
        end
    end

    // Render return path: data arrives the ce slot after the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd_valid <= 1'b0;
            rnd_rdata <= 8'd0;
        end else if (ce) begin
            rnd_valid <= rnd_win_s;
            if (rnd_valid) begin
                rnd_rdata <= vram_din;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Randomised and directed bench for ppu_vram_arbiter against a slot-level reference model.
module tb_ppu_vram_arbiter;

    localparam int STARVE = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = 14'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic        cpu_busy;
    logic [7:0]  cpu_rdata;
    logic        cpu_overrun;
    logic        cpu_overrun_clr = 1'b0;
    logic        rnd_req = 1'b0;
    logic [13:0] rnd_addr = 14'd0;
    logic        rnd_grant;
    logic        rnd_valid;
    logic [7:0]  rnd_rdata;
    logic [13:0] vram_a;
    logic        vram_r;
    logic        vram_w;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din = 8'd0;

    ppu_vram_arbiter #(.STARVE_LIMIT(STARVE), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_overrun(cpu_overrun),
        .cpu_overrun_clr(cpu_overrun_clr),
        .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_grant(rnd_grant),
        .rnd_valid(rnd_valid), .rnd_rdata(rnd_rdata),
        .vram_a(vram_a), .vram_r(vram_r), .vram_w(vram_w), .vram_dout(vram_dout),
        .vram_din(vram_din)
    );

    always #5 clk = ~clk;

    // Bench-side VRAM driven by the DUT strobes; read data appears on the next slot.
    logic [7:0] mem [0:16383];
    always @(posedge clk) begin
        if (vram_r) vram_din <= mem[vram_a];
        if (vram_w) mem[vram_a] <= vram_dout;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the CPU is waiting for, how many slots it lost, what data is in flight.
    logic [7:0]  model_mem [0:16383];
    bit          m_pend, m_pend_we, m_rdwait, m_ovr, m_rvalid;
    logic [13:0] m_pend_addr;
    logic [7:0]  m_pend_wd, m_rd_val, m_buf, m_rnd_val, m_rdata;
    int          m_losses;

    task automatic model_clear();
        m_pend = 1'b0; m_pend_we = 1'b0; m_rdwait = 1'b0; m_ovr = 1'b0; m_rvalid = 1'b0;
        m_pend_addr = 14'd0; m_pend_wd = 8'd0; m_buf = 8'd0; m_rdata = 8'd0;
        m_losses = 0;
    endtask

    task automatic set_mem(input logic [13:0] a, input logic [7:0] v);
        mem[a] = v;
        model_mem[a] = v;
    endtask

    task automatic step(input bit i_ce, input bit i_rst, input bit i_req, input bit i_we,
                        input logic [13:0] i_addr, input logic [7:0] i_wd, input bit i_clr,
                        input bit i_rr, input logic [13:0] i_ra);
        bit slot, e_rnd, e_cpu, e_w, e_r, old_busy;
        logic [13:0] e_a;
        logic [7:0]  e_dout;
        @(negedge clk);
        ce = i_ce; reset = i_rst; cpu_req = i_req; cpu_we = i_we; cpu_addr = i_addr;
        cpu_wdata = i_wd; cpu_overrun_clr = i_clr; rnd_req = i_rr; rnd_addr = i_ra;
        #1;
        if (i_rst) model_clear();
        slot   = i_ce && !i_rst;
        e_rnd  = slot && i_rr && !(m_pend && m_losses >= STARVE);
        e_cpu  = slot && m_pend && !e_rnd;
        e_w    = e_cpu && m_pend_we;
        e_r    = e_rnd || (e_cpu && !m_pend_we);
        e_a    = e_rnd ? i_ra : (e_cpu ? m_pend_addr : 14'd0);
        e_dout = e_w ? m_pend_wd : 8'd0;
        check_val("rnd_grant", 32'(rnd_grant), 32'(e_rnd));
        check_val("vram_r", 32'(vram_r), 32'(e_r));
        check_val("vram_w", 32'(vram_w), 32'(e_w));
        check_val("vram_a", 32'(vram_a), 32'(e_a));
        check_val("vram_dout", 32'(vram_dout), 32'(e_dout));
        check_val("cpu_busy", 32'(cpu_busy), 32'(m_pend || m_rdwait));
        check_val("cpu_rdata", 32'(cpu_rdata), 32'(m_buf));
        check_val("cpu_overrun", 32'(cpu_overrun), 32'(m_ovr));
        check_val("rnd_valid", 32'(rnd_valid), 32'(m_rvalid));
        check_val("rnd_rdata", 32'(rnd_rdata), 32'(m_rdata));
        if (slot) begin
            old_busy = m_pend || m_rdwait;
            if (m_rvalid) m_rdata = m_rnd_val;
            m_rvalid = e_rnd;
            if (e_rnd) m_rnd_val = model_mem[i_ra];
            if (m_rdwait) begin
                m_buf = m_rd_val;
                m_rdwait = 1'b0;
            end
            if (e_cpu) begin
                if (m_pend_we) model_mem[m_pend_addr] = m_pend_wd;
                else begin
                    m_rdwait = 1'b1;
                    m_rd_val = model_mem[m_pend_addr];
                end
                m_pend = 1'b0;
                m_losses = 0;
            end else if (e_rnd && m_pend && m_losses < STARVE) begin
                m_losses++;
            end
            if (i_req && old_busy) m_ovr = 1'b1;
            else if (i_clr) m_ovr = 1'b0;
            if (i_req && !old_busy) begin
                m_pend = 1'b1; m_pend_we = i_we; m_pend_addr = i_addr; m_pend_wd = i_wd;
                m_losses = 0;
            end
        end
    endtask

    task automatic idle(input bit i_rr);
        step(1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, i_rr, 14'h0333);
    endtask

    int gcnt;

    initial begin
        for (int i = 0; i < 16384; i++) set_mem(14'(i), 8'(i * 7 + 3));
        model_clear();
        set_mem(14'h0100, 8'h11);
        set_mem(14'h0123, 8'h5C);
        set_mem(14'h0005, 8'h3C);

        // Reset state
        step(1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b1, 14'h0001);
        check_val("rst_grant", 32'(rnd_grant), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 14'd0);
        check_val("rst_busy", 32'(cpu_busy), 32'd0);

        // CPU write on an idle arbiter
        step(1'b1, 1'b0, 1'b1, 1'b1, 14'h2005, 8'hA7, 1'b0, 1'b0, 14'd0);
        idle(1'b0);
        check_val("wr_strobe", 32'(vram_w), 32'd1);
        check_val("wr_addr", 32'(vram_a), 32'h2005);
        check_val("wr_data", 32'(vram_dout), 32'hA7);
        idle(1'b0);
        check_val("wr_busy_drop", 32'(cpu_busy), 32'd0);

        // Read buffer returns the previous value until capture
        step(1'b1, 1'b0, 1'b1, 1'b0, 14'h0100, 8'd0, 1'b0, 1'b0, 14'd0);
        idle(1'b0); idle(1'b0); idle(1'b0);
        check_val("rd_prev", 32'(cpu_rdata), 32'h11);
        step(1'b1, 1'b0, 1'b1, 1'b0, 14'h0123, 8'd0, 1'b0, 1'b0, 14'd0);
        idle(1'b0);
        check_val("rd_strobe", 32'(vram_r), 32'd1);
        check_val("rd_addr", 32'(vram_a), 32'h0123);
        idle(1'b0);
        check_val("rd_hold", 32'(cpu_rdata), 32'h11);
        check_val("rd_busy_wait", 32'(cpu_busy), 32'd1);
        idle(1'b0);
        check_val("rd_new", 32'(cpu_rdata), 32'h5C);
        check_val("rd_busy_drop", 32'(cpu_busy), 32'd0);

        // Starvation: render holds the port for exactly STARVE slots
        step(1'b1, 1'b0, 1'b1, 1'b0, 14'h0200, 8'd0, 1'b0, 1'b1, 14'h0300);
        gcnt = 0;
        for (int k = 0; k < STARVE; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b1, 14'(14'h0301 + k));
            gcnt += int'(rnd_grant);
        end
        check_val("starve_grants", 32'(gcnt), 32'(STARVE));
        idle(1'b1);
        check_val("starve_cpu_slot", 32'(rnd_grant), 32'd0);
        check_val("starve_cpu_addr", 32'(vram_a), 32'h0200);
        idle(1'b1);
        check_val("starve_resume", 32'(rnd_grant), 32'd1);
        idle(1'b0); idle(1'b0);

        // Overrun: dropped request, sticky flag, set beats clear
        step(1'b1, 1'b0, 1'b1, 1'b1, 14'h0010, 8'hD1, 1'b0, 1'b1, 14'h0001);
        step(1'b1, 1'b0, 1'b1, 1'b1, 14'h0011, 8'hD2, 1'b0, 1'b1, 14'h0002);
        idle(1'b0);
        check_val("ovr_set", 32'(cpu_overrun), 32'd1);
        check_val("ovr_first_addr", 32'(vram_a), 32'h0010);
        idle(1'b0);
        check_val("ovr_no_extra", 32'(vram_w), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b1, 1'b0, 14'd0);
        idle(1'b0);
        check_val("ovr_clr", 32'(cpu_overrun), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 14'h0012, 8'hD3, 1'b0, 1'b1, 14'h0003);
        step(1'b1, 1'b0, 1'b1, 1'b1, 14'h0013, 8'hD4, 1'b1, 1'b1, 14'h0004);
        idle(1'b0);
        check_val("ovr_set_wins", 32'(cpu_overrun), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b1, 1'b0, 14'd0);

        // ce toggling during a pending read
        step(1'b1, 1'b0, 1'b1, 1'b0, 14'h0005, 8'd0, 1'b0, 1'b0, 14'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 14'd0);
        check_val("ce0_no_strobe", 32'(vram_r), 32'd0);
        idle(1'b0);
        check_val("ce1_strobe", 32'(vram_r), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 14'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 14'd0);
        check_val("ce0_no_capture", 32'(cpu_busy), 32'd1);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 14'd0);
        check_val("ce_capture", 32'(cpu_rdata), 32'h3C);

        // Reset while a read is in flight
        step(1'b1, 1'b0, 1'b1, 1'b0, 14'h0123, 8'd0, 1'b0, 1'b0, 14'd0);
        idle(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b1, 14'h0007);
        check_val("rstmid_busy", 32'(cpu_busy), 32'd0);
        check_val("rstmid_rdata", 32'(cpu_rdata), 32'd0);
        check_val("rstmid_strobe", 32'(vram_r), 32'd0);
        idle(1'b0);
        check_val("rstmid_after", 32'(cpu_rdata), 32'd0);

        // Randomised traffic, alternating heavy and light render load
        for (int i = 0; i < 4000; i++) begin
            bit rr;
            rr = ((i % 400) < 200) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 14'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 9) == 0,
                 rr, 14'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Shares the single PPU VRAM port between two requesters: the CPU-side PPUDATA ($2007) access path and the PPU background/render fetch path.
- Render fetches have priority. CPU accesses are held in a one-deep pending slot and serviced in the first free slot.
- A starvation counter guarantees forward progress for the CPU.
- Also owns the PPUDATA read buffer, which returns the previous read value.

Parameters:
- STARVE_LIMIT, 8: number of consecutive ce slots a pending CPU access may lose to render before it is forced through.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  PPU clock (3x CPU clock).
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; one VRAM slot per ce-high cycle.
- cpu_req  in  1  single-cycle (ce-qualified) PPUDATA access request.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  14  VRAM address (the PPUADDR value).
- cpu_wdata  in  8  write data.
- cpu_busy  out  1  pending slot occupied.
- cpu_rdata  out  8  PPUDATA read buffer contents.
- cpu_overrun  out  1  sticky: a cpu_req arrived while the pending slot was occupied.
- cpu_overrun_clr  in  1  clears cpu_overrun.
- rnd_req  in  1  render fetch request this slot.
- rnd_addr  in  14  render fetch address.
- rnd_grant  out  1  render owns the VRAM port this slot.
- rnd_valid  out  1  render read data is valid on rnd_rdata.
- rnd_rdata  out  8  registered render read data.
- vram_a  out  14  VRAM address.
- vram_r  out  1  VRAM read strobe.
- vram_w  out  1  VRAM write strobe.
- vram_dout  out  8  VRAM write data.
- vram_din  in  8  VRAM read data; valid on the ce slot after vram_r.

Behaviour:
- Reset (async): every output register, the pending slot, counters and cpu_rdata go to 0. No strobes are issued.
- All state advances only when ce=1. With ce=0, state holds and vram_r/vram_w are 0.

Pending slot (CPU_IDLE / CPU_PEND):
- cpu_req in CPU_IDLE latches {cpu_we, cpu_addr, cpu_wdata} and moves to CPU_PEND. cpu_busy=1 from the next cycle.
- cpu_req in CPU_PEND drops the request and sets cpu_overrun.
- If cpu_overrun_clr and a set event occur in the same cycle, set wins.

Slot arbitration (combinational from registered state, evaluated every ce cycle):
- CPU_PEND and starve_cnt >= STARVE_LIMIT: CPU wins. rnd_grant=0 even if rnd_req=1.
- Otherwise, rnd_req=1: render wins. rnd_grant=1, vram_a=rnd_addr, vram_r=1.
  - In this case, if CPU_PEND, starve_cnt increments, saturating at STARVE_LIMIT.
- Otherwise, CPU_PEND: CPU wins.
- Otherwise: idle, vram_a=0, no strobes.

CPU service:
- Write: vram_w=1, vram_a=pend_addr, vram_dout=pend_wdata. Return to CPU_IDLE next cycle.
- Read: vram_r=1. Go to CPU_RDWAIT. On the next ce cycle, capture vram_din into cpu_rdata, then go to CPU_IDLE.
  - CPU_RDWAIT does not block render. A new cpu_req during CPU_RDWAIT is treated as busy (overrun).
- starve_cnt resets to 0 whenever the CPU is granted.
- cpu_busy=1 in CPU_PEND and CPU_RDWAIT.

Render data:
- rnd_valid is rnd_grant delayed by one ce cycle.
- rnd_rdata captures vram_din on that cycle.

Simultaneous events:
- A cpu_req arriving in the same cycle render is granted only latches. Earliest CPU service is the next slot.

Reset mid-operation:
- A pending or in-flight access is discarded. cpu_rdata returns to 0.

Test Plan:
- Idle arbiter, CPU write addr 0x2005 data 0xA7 -> next ce cycle vram_w=1, vram_a=0x2005, vram_dout=0xA7; cpu_busy low the cycle after.
- CPU read 0x0123, memory returns 0x5C; an earlier buffer value of 0x11 -> cpu_rdata stays 0x11 until capture, becomes 0x5C one ce cycle after vram_r, and cpu_busy drops after capture.
- rnd_req held high continuously plus a CPU read pending, STARVE_LIMIT=8 -> render granted 8 slots, 9th slot rnd_grant=0 and CPU served, then render resumes and starve_cnt=0.
- Second cpu_req while busy -> request ignored (no extra VRAM access), cpu_overrun=1 until cpu_overrun_clr; clr and new overrun in the same cycle leaves it 1.
- ce toggled 1/0 during a pending read -> no strobes on ce=0 cycles, data captured on the next ce=1 slot only.
- Assert reset while in CPU_RDWAIT -> outputs 0 immediately (async), no capture, cpu_busy=0 after release.
